// File: rtl/gpp_run_ctrl_if.sv
// Handshake and memory/core signal bundle for the run sequencer.
// The master side is the sequencer; the slave side is everything it drives.
interface gpp_run_ctrl_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned IA = 10,
  parameter int unsigned DW = 16,
  parameter int unsigned DA = 9,
  parameter int unsigned CW = 16
);
  logic          start;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          im_we;
  logic [IA-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          core_rst;
  logic          core_run;
  logic          core_halt;
  logic          dm_re;
  logic [DA-1:0] dm_addr;
  logic [DW-1:0] dm_rdata;
  logic          dump_valid;
  logic [DA-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_ready;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  modport master (
    input  start, ld_valid, ld_data, ld_last, core_halt, dm_rdata, dump_ready,
    output ld_ready, im_we, im_addr, im_wdata, core_rst, core_run, dm_re, dm_addr,
           dump_valid, dump_addr, dump_data, busy, done, timeout, cycle_count
  );

  modport slave (
    output start, ld_valid, ld_data, ld_last, core_halt, dm_rdata, dump_ready,
    input  ld_ready, im_we, im_addr, im_wdata, core_rst, core_run, dm_re, dm_addr,
           dump_valid, dump_addr, dump_data, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/gpp_run_ctrl.sv
// Run sequencer: loads a program with the core held in reset, runs the core until
// HALT or the cycle budget, then freezes it and streams data memory out.
module gpp_run_ctrl #(
  parameter int unsigned IW         = 16,
  parameter int unsigned IA         = 10,
  parameter int unsigned DW         = 16,
  parameter int unsigned DA         = 9,
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned DUMP_WORDS = 512
) (
  input logic            clk,
  input logic            rst,
  gpp_run_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRST, S_RUN, S_DRD, S_DOUT, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [IA-1:0] ld_ptr, ld_ptr_n;
  logic          crst_cnt, crst_cnt_n;
  logic [CW-1:0] cyc, cyc_n;
  logic          tmo, tmo_n;
  logic [DA-1:0] dptr, dptr_n;
  logic [DW-1:0] dword, dword_n;
  logic          first, first_n;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_ptr   <= '0;
      crst_cnt <= 1'b0;
      cyc      <= '0;
      tmo      <= 1'b0;
      dptr     <= '0;
      dword    <= '0;
      first    <= 1'b0;
    end else begin
      state    <= state_n;
      ld_ptr   <= ld_ptr_n;
      crst_cnt <= crst_cnt_n;
      cyc      <= cyc_n;
      tmo      <= tmo_n;
      dptr     <= dptr_n;
      dword    <= dword_n;
      first    <= first_n;
    end
  end

  assign bus.cycle_count = cyc;
  assign bus.timeout     = tmo;

  // Next-state and output decode
  always_comb begin
    state_n        = state;
    ld_ptr_n       = ld_ptr;
    crst_cnt_n     = crst_cnt;
    cyc_n          = cyc;
    tmo_n          = tmo;
    dptr_n         = dptr;
    dword_n        = dword;
    first_n        = first;
    bus.ld_ready   = 1'b0;
    bus.im_we      = 1'b0;
    bus.im_addr    = '0;
    bus.im_wdata   = IW'(0);
    bus.core_rst   = 1'b0;
    bus.core_run   = 1'b0;
    bus.dm_re      = 1'b0;
    bus.dm_addr    = '0;
    bus.dump_valid = 1'b0;
    bus.dump_addr  = '0;
    bus.dump_data  = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        bus.core_rst = (state == S_IDLE);
        bus.done     = (state == S_DONE);
        if (bus.start) begin
          state_n  = S_LOAD;
          ld_ptr_n = '0;
          cyc_n    = '0;
          tmo_n    = 1'b0;
          dptr_n   = '0;
        end
      end

      S_LOAD: begin
        bus.ld_ready = 1'b1;
        bus.core_rst = 1'b1;
        bus.busy     = 1'b1;
        bus.im_we    = bus.ld_valid;
        bus.im_addr  = ld_ptr;
        bus.im_wdata = bus.ld_data;
        if (bus.ld_valid) begin
          // The pointer saturates so the top word is never followed by a write to 0
          if (ld_ptr != {IA{1'b1}}) ld_ptr_n = ld_ptr + IA'(1);
          if (bus.ld_last || ld_ptr == {IA{1'b1}}) begin
            state_n    = S_CRST;
            crst_cnt_n = 1'b0;
          end
        end
      end

      S_CRST: begin
        bus.core_rst = 1'b1;
        bus.busy     = 1'b1;
        crst_cnt_n   = 1'b1;
        if (crst_cnt) state_n = S_RUN;
      end

      S_RUN: begin
        bus.core_run = 1'b1;
        bus.busy     = 1'b1;
        // HALT takes priority over the budget; the count freezes on the exit cycle
        if (bus.core_halt) begin
          state_n = S_DRD;
          tmo_n   = 1'b0;
        end else if (cyc == CW'(MAX_CYCLES - 1)) begin
          state_n = S_DRD;
          tmo_n   = 1'b1;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end

      S_DRD: begin
        bus.busy    = 1'b1;
        bus.dm_re   = 1'b1;
        bus.dm_addr = dptr;
        state_n     = S_DOUT;
        first_n     = 1'b1;
      end

      S_DOUT: begin
        bus.busy       = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_addr  = dptr;
        // Read data arrives during the first DOUT cycle; it is held in dword afterwards
        bus.dump_data  = first ? bus.dm_rdata : dword;
        first_n        = 1'b0;
        if (first) dword_n = bus.dm_rdata;
        if (bus.dump_ready) begin
          if (dptr == DA'(DUMP_WORDS - 1)) begin
            state_n = S_DONE;
          end else begin
            dptr_n  = dptr + DA'(1);
            state_n = S_DRD;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpp_run_ctrl.sv
// Self-checking bench for gpp_run_ctrl: vector table for the first session,
// scoreboarded program writes and dump words, and hand-written corner sequences.
module tb_gpp_run_ctrl;
  localparam int unsigned IW = 16, IA = 10, DW = 16, DA = 9, CW = 16;
  localparam int unsigned MAXC = 20, NDUMP = 4, NVEC = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpp_run_ctrl_if #(.IW(IW), .IA(IA), .DW(DW), .DA(DA), .CW(CW)) bus ();

  gpp_run_ctrl #(
    .IW(IW), .IA(IA), .DW(DW), .DA(DA), .CW(CW),
    .MAX_CYCLES(MAXC), .DUMP_WORDS(NDUMP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          core_halt;
    logic          ld_ready;
    logic          im_we;
    logic [IA-1:0] im_addr;
    logic          core_rst;
    logic          core_run;
    logic          dm_re;
    logic [DA-1:0] dm_addr;
    logic [CW-1:0] cycle_count;
    logic          busy;
  } vec_t;

  typedef struct packed { logic [IA-1:0] addr; logic [IW-1:0] data; } ld_exp_t;
  typedef struct packed { logic [DA-1:0] addr; logic [DW-1:0] data; } dump_exp_t;

  vec_t          vecs [NVEC];
  ld_exp_t       load_q [$];
  dump_exp_t     dump_q [$];
  logic [DW-1:0] dmem [0:(1<<DA)-1];
  int            n_chk, n_pass, run_cycles, hold_cnt, rc0, h0;
  logic [CW-1:0] first_cc;

  // Data memory: registered read, one cycle after dm_re
  always @(posedge clk) begin
    if (rst) bus.dm_rdata <= '0;
    else if (bus.dm_re) bus.dm_rdata <= dmem[bus.dm_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mon();
    ld_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.im_we) begin
        chk("im_write_expected", 32'(load_q.size() != 0), 32'(1));
        if (load_q.size() != 0) begin
          e = load_q.pop_front();
          chk("im_addr", 32'(bus.im_addr), 32'(e.addr));
          chk("im_wdata", 32'(bus.im_wdata), 32'(e.data));
        end
      end
    end
  endtask

  task automatic dump_mon();
    dump_exp_t     e;
    logic          held = 1'b0;
    logic [DA-1:0] ha;
    logic [DW-1:0] hd;
    forever begin
      @(negedge clk);
      if (bus.dump_valid) begin
        if (held) begin
          chk("dump_hold_addr", 32'(bus.dump_addr), 32'(ha));
          chk("dump_hold_data", 32'(bus.dump_data), 32'(hd));
        end
        if (bus.dump_ready) begin
          chk("dump_expected", 32'(dump_q.size() != 0), 32'(1));
          if (dump_q.size() != 0) begin
            e = dump_q.pop_front();
            chk("dump_addr", 32'(bus.dump_addr), 32'(e.addr));
            chk("dump_data", 32'(bus.dump_data), 32'(e.data));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          ha   = bus.dump_addr;
          hd   = bus.dump_data;
          hold_cnt++;
        end
      end else begin
        held = 1'b0;
      end
    end
  endtask

  task automatic run_mon();
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_run) begin
        if (!prev) first_cc = bus.cycle_count;
        run_cycles++;
      end
      prev = bus.core_run;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".core_rst"},    32'(bus.core_rst), 32'(1));
    chk({tag, ".core_run"},    32'(bus.core_run), 32'(0));
    chk({tag, ".ld_ready"},    32'(bus.ld_ready), 32'(0));
    chk({tag, ".im_we"},       32'(bus.im_we), 32'(0));
    chk({tag, ".im_addr"},     32'(bus.im_addr), 32'(0));
    chk({tag, ".im_wdata"},    32'(bus.im_wdata), 32'(0));
    chk({tag, ".dm_re"},       32'(bus.dm_re), 32'(0));
    chk({tag, ".dm_addr"},     32'(bus.dm_addr), 32'(0));
    chk({tag, ".dump_valid"},  32'(bus.dump_valid), 32'(0));
    chk({tag, ".dump_addr"},   32'(bus.dump_addr), 32'(0));
    chk({tag, ".dump_data"},   32'(bus.dump_data), 32'(0));
    chk({tag, ".busy"},        32'(bus.busy), 32'(0));
    chk({tag, ".done"},        32'(bus.done), 32'(0));
    chk({tag, ".timeout"},     32'(bus.timeout), 32'(0));
    chk({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(0));
  endtask

  task automatic set_mem_and_expect(input logic [DW-1:0] base);
    dump_exp_t e;
    for (int i = 0; i < int'(NDUMP); i++) begin
      dmem[i] = base + DW'(i);
      e.addr  = DA'(i);
      e.data  = base + DW'(i);
      dump_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [IW-1:0] base, input bit last);
    ld_exp_t e;
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = base + IW'(i);
      bus.ld_last  = last && (i == n - 1);
      e.addr = IA'(i);
      e.data = base + IW'(i);
      load_q.push_back(e);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Drives core_halt on run cycle halt_at (0 = never) and dump_ready with an optional stall
  task automatic run_to_done(input int halt_at, input int stall_word, input int stall_cycles,
                             input string tag);
    int stalled = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      bus.core_halt = (halt_at > 0) && bus.core_run && (bus.cycle_count == CW'(halt_at - 1));
      if (bus.dump_valid && int'(bus.dump_addr) == stall_word && stalled < stall_cycles) begin
        bus.dump_ready = 1'b0;
        stalled++;
      end else begin
        bus.dump_ready = 1'b1;
      end
      @(negedge clk);
      seen = bus.done;
      tick();
    end
    bus.core_halt  = 1'b0;
    bus.dump_ready = 1'b0;
    chk({tag, ".done_reached"}, 32'(seen), 32'(1));
    chk({tag, ".dump_sb_empty"}, 32'(dump_q.size()), 32'(0));
    chk({tag, ".load_sb_empty"}, 32'(load_q.size()), 32'(0));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; run_cycles = 0; hold_cnt = 0; first_cc = '1;
    rst = 1'b1;
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.core_halt = 1'b0; bus.dump_ready = 1'b0;
    for (int i = 0; i < (1 << DA); i++) dmem[i] = '0;

    // Session 1 vectors: 5-word load, 2 CRST cycles, HALT on 12th run cycle, DRD
    for (int i = 0; i < int'(NVEC); i++) begin
      vecs[i] = '0;
      vecs[i].busy = 1'b1;
      if (i < 5) begin
        vecs[i].ld_valid = 1'b1;
        vecs[i].ld_data  = 16'h1001 + IW'(i);
        vecs[i].ld_last  = (i == 4);
        vecs[i].ld_ready = 1'b1;
        vecs[i].im_we    = 1'b1;
        vecs[i].im_addr  = IA'(i);
        vecs[i].core_rst = 1'b1;
      end else if (i < 7) begin
        vecs[i].core_rst = 1'b1;
      end else if (i < 19) begin
        vecs[i].core_halt   = (i == 18);
        vecs[i].core_run    = 1'b1;
        vecs[i].cycle_count = CW'(i - 7);
      end else begin
        vecs[i].dm_re       = 1'b1;
        vecs[i].dm_addr     = '0;
        vecs[i].cycle_count = CW'(11);
      end
    end

    fork
      load_mon();
      dump_mon();
      run_mon();
    join_none

    repeat (3) tick();
    @(negedge clk);
    check_idle("por");
    tick();
    rst = 1'b0;

    // Session 1: table-driven load/run, then dump with a 3-cycle stall on word 1
    set_mem_and_expect(16'd7);
    h0 = hold_cnt;
    pulse_start();
    for (int i = 0; i < int'(NVEC); i++) begin
      ld_exp_t e;
      bus.ld_valid  = vecs[i].ld_valid;
      bus.ld_data   = vecs[i].ld_data;
      bus.ld_last   = vecs[i].ld_last;
      bus.core_halt = vecs[i].core_halt;
      if (vecs[i].ld_valid && vecs[i].im_we) begin
        e.addr = vecs[i].im_addr;
        e.data = vecs[i].ld_data;
        load_q.push_back(e);
      end
      @(negedge clk);
      chk($sformatf("v%0d.ld_ready", i), 32'(bus.ld_ready), 32'(vecs[i].ld_ready));
      chk($sformatf("v%0d.im_we", i), 32'(bus.im_we), 32'(vecs[i].im_we));
      if (vecs[i].im_we) chk($sformatf("v%0d.im_addr", i), 32'(bus.im_addr), 32'(vecs[i].im_addr));
      chk($sformatf("v%0d.core_rst", i), 32'(bus.core_rst), 32'(vecs[i].core_rst));
      chk($sformatf("v%0d.core_run", i), 32'(bus.core_run), 32'(vecs[i].core_run));
      chk($sformatf("v%0d.dm_re", i), 32'(bus.dm_re), 32'(vecs[i].dm_re));
      if (vecs[i].dm_re) chk($sformatf("v%0d.dm_addr", i), 32'(bus.dm_addr), 32'(vecs[i].dm_addr));
      chk($sformatf("v%0d.cycle_count", i), 32'(bus.cycle_count), 32'(vecs[i].cycle_count));
      chk($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      tick();
    end
    bus.core_halt = 1'b0;
    chk("s1.timeout_after_halt", 32'(bus.timeout), 32'(0));
    run_to_done(0, 1, 3, "s1");
    chk("s1.stall_cycles", 32'(hold_cnt - h0), 32'(3));
    chk("s1.done", 32'(bus.done), 32'(1));
    chk("s1.busy", 32'(bus.busy), 32'(0));
    chk("s1.core_rst", 32'(bus.core_rst), 32'(0));
    chk("s1.core_run", 32'(bus.core_run), 32'(0));
    chk("s1.cycle_count", 32'(bus.cycle_count), 32'(11));

    // Session 2: HALT coincides with the budget cycle
    set_mem_and_expect(16'hA000);
    rc0 = run_cycles;
    pulse_start();
    load_words(3, 16'h2001, 1'b1);
    run_to_done(int'(MAXC), -1, 0, "s2");
    chk("s2.run_cycles", 32'(run_cycles - rc0), 32'(MAXC));
    chk("s2.cycle_count", 32'(bus.cycle_count), 32'(MAXC - 1));
    chk("s2.timeout", 32'(bus.timeout), 32'(0));

    // Session 3: no HALT, budget expires
    set_mem_and_expect(16'hB000);
    rc0 = run_cycles;
    pulse_start();
    load_words(1, 16'h2101, 1'b1);
    run_to_done(0, -1, 0, "s3");
    chk("s3.run_cycles", 32'(run_cycles - rc0), 32'(MAXC));
    chk("s3.cycle_count", 32'(bus.cycle_count), 32'(MAXC - 1));
    chk("s3.timeout", 32'(bus.timeout), 32'(1));

    // Session 4: start ignored in RUN, then reset mid-run
    pulse_start();
    load_words(2, 16'h3001, 1'b1);
    for (int c = 0; c < 10 && !bus.core_run; c++) tick();
    chk("s4.running", 32'(bus.core_run), 32'(1));
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s4.start_ignored.core_run", 32'(bus.core_run), 32'(1));
    chk("s4.start_ignored.ld_ready", 32'(bus.ld_ready), 32'(0));
    chk("s4.start_ignored.core_rst", 32'(bus.core_rst), 32'(0));
    chk("s4.start_ignored.cycle_count", 32'(bus.cycle_count), 32'(3));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_idle("s4.rst");
    tick();
    rst = 1'b0;
    chk("s4.load_sb_empty", 32'(load_q.size()), 32'(0));

    // Session 5: fresh session after reset, count restarts at 0
    set_mem_and_expect(16'hC000);
    rc0 = run_cycles;
    pulse_start();
    load_words(2, 16'h5001, 1'b1);
    run_to_done(4, -1, 0, "s5");
    chk("s5.first_cycle_count", 32'(first_cc), 32'(0));
    chk("s5.run_cycles", 32'(run_cycles - rc0), 32'(4));
    chk("s5.cycle_count", 32'(bus.cycle_count), 32'(3));
    chk("s5.timeout", 32'(bus.timeout), 32'(0));

    // Session 6: full 1024-word load without ld_last ends at the top address
    set_mem_and_expect(16'hD000);
    pulse_start();
    load_words(1 << IA, 16'h4000, 1'b0);
    for (int j = 0; j < 2; j++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'hDEAD;
      @(negedge clk);
      chk($sformatf("s6.ld_ready_after_full.%0d", j), 32'(bus.ld_ready), 32'(0));
      chk($sformatf("s6.im_we_after_full.%0d", j), 32'(bus.im_we), 32'(0));
      tick();
    end
    bus.ld_valid = 1'b0;
    run_to_done(1, -1, 0, "s6");
    chk("s6.cycle_count", 32'(bus.cycle_count), 32'(0));
    chk("s6.timeout", 32'(bus.timeout), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpp_run_ctrl.md
Name: gpp_run_ctrl

Overview:
Run sequencer for the accumulator core. It streams a program into instruction memory and holds the core in reset during the load. It then releases the core and runs it until HALT or a cycle budget expires. Finally it freezes the core and streams the data-memory contents out over a valid/ready port.

Parameters:
IW, 16, instruction word width
IA, 10, instruction memory address width
DW, 16, data memory word width
DA, 9, data memory address width (512 words)
CW, 16, cycle counter width
MAX_CYCLES, 1000, run budget in core clock-enabled cycles (1..2^CW-1)
DUMP_WORDS, 512, number of data words dumped from address 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a load/run/dump session
ld_valid  in  1  program word available
ld_data  in  IW  program word
ld_last  in  1  qualifies final program word
ld_ready  out  1  controller accepts a program word
im_we  out  1  instruction memory write enable
im_addr  out  IA  instruction memory write address
im_wdata  out  IW  instruction memory write data
core_rst  out  1  active-high hold-in-reset to core
core_run  out  1  core clock enable
core_halt  in  1  core decoded HALT, level
dm_re  out  1  data memory read enable
dm_addr  out  DA  data memory read address
dm_rdata  in  DW  read data, valid 1 cycle after dm_re
dump_valid  out  1  dump word valid
dump_addr  out  DA  address of dump word
dump_data  out  DW  dump word
dump_ready  in  1  sink accepts dump word
busy  out  1  state not IDLE/DONE
done  out  1  session complete
timeout  out  1  run ended by budget, not HALT
cycle_count  out  CW  run cycles consumed

Behaviour:
- States: IDLE, LOAD, CRST, RUN, DRD, DOUT, DONE.
- Reset, applicable in any state and including mid-session: state=IDLE, core_rst=1, core_run=0, and every other output and counter is 0.
- IDLE/DONE: on start go to LOAD; clear load pointer, cycle_count, timeout and dump pointer; done drops. start is ignored in all other states.
- LOAD: ld_ready=1, core_rst=1.
  - im_we = ld_valid (combinational), im_addr = pointer, im_wdata = ld_data.
  - Each accepted word increments the pointer.
  - ld_last accepted, or acceptance at pointer = 2^IA-1, goes to CRST; the pointer does not wrap.
- CRST: core_rst=1 for exactly 2 cycles, then RUN.
- RUN: core_rst=0, core_run=1; cycle_count increments every RUN cycle.
  - core_halt=1 goes to DRD with timeout=0.
  - Otherwise, if cycle_count == MAX_CYCLES-1 this cycle, go to DRD with timeout=1.
  - If both occur in the same cycle, halt wins and timeout=0.
  - cycle_count holds its final value after RUN.
- Core frozen from DRD onward: core_run=0 and core_rst=0, so register state stays observable.
- DRD: dm_re=1 for one cycle with dm_addr = dump pointer; next state DOUT.
- DOUT: latch dm_rdata on entry.
  - dump_valid=1, dump_addr = pointer, dump_data = latched word.
  - dump_data and dump_addr are held stable while dump_ready=0.
  - On dump_ready: if pointer == DUMP_WORDS-1 go to DONE, else increment the pointer and go to DRD.
  - Throughput is at most 1 word per 2 cycles.
- DONE: done=1, busy=0, core_rst=0, core_run=0. Remains until start or rst.
- busy=1 in LOAD, CRST, RUN, DRD, DOUT.

Test Plan:
- Load 5 words (0x1001..0x1005, last on the 5th) with ld_valid constant high -> im_we for 5 consecutive cycles at addresses 0..4; exactly 2 CRST cycles follow with core_rst=1; then core_run rises.
- Core asserts core_halt on its 12th run cycle -> cycle_count=11 after that cycle, timeout=0, core_run=0 on the next cycle, dm_re at address 0.
- MAX_CYCLES=20 and core_halt never asserted -> exactly 20 core_run cycles, cycle_count=19, timeout=1.
- core_halt asserted on the budget cycle (MAX_CYCLES=20) -> timeout=0.
- Dump with DUMP_WORDS=4, memory holding 7,8,9,10, and dump_ready stalled low for 3 cycles on word 1 -> sink receives (0,7),(1,8),(2,9),(3,10) in order; word 1 is held stable during the stall; done=1 after the 4th handshake.
- rst pulsed during RUN, then start pulsed with a fresh 2-word load -> IDLE with core_rst=1 and all outputs 0 after the reset; the second session completes normally with cycle_count restarting at 0.
- 1024 words loaded without ld_last (IA=10) -> load ends after address 1023, which is written once; ld_ready=0 afterwards; no write to address 0 again.
- start pulsed during RUN -> ignored, no state change.
